// File: rtl/bju_issue_ctrl.sv
// bju_issue_ctrl: in-order issue sequencer for the branch/jump unit.
//
// Micro-ops from dispatch are buffered in a DEPTH-entry circular queue.
// The head entry is presented combinationally to the bju every cycle it
// can issue. The bju result is registered into a single output stage (S1).
// S1 drives the register writeback handshake and a one-cycle frontend
// redirect pulse. A taken branch/jump squashes every younger queued entry.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   flush               external pipeline flush, highest priority
//   enq_*               dispatch interface (valid/ready plus op fields)
//   bju_*  (out)        head entry driven to the combinational bju
//   bju_dest, bju_redirect_valid, bju_redirect_target (in)
//                       bju results for the presented entry, same cycle
//   wb_valid/ready/rd/data   writeback handshake out of S1
//   redirect_valid/target    one-cycle redirect pulse, target held with S1
//   q_count             queue occupancy
//
// Optional build macro BJU_PERF_CNT_EN adds perf_br_cnt (issued ops) and
// perf_redirect_cnt (issued ops that redirected). Neither is cleared by flush.
module bju_issue_ctrl #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 48,
  parameter int RD_WIDTH   = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      enq_valid,
  output logic                      enq_ready,
  input  logic [DATA_WIDTH-1:0]     enq_src1,
  input  logic [DATA_WIDTH-1:0]     enq_src2,
  input  logic [DATA_WIDTH-1:0]     enq_offset,
  input  logic [PC_WIDTH-1:0]       enq_pc,
  input  logic [7:0]                enq_cx_type,
  input  logic [RD_WIDTH-1:0]       enq_rd,
  input  logic                      enq_rd_wen,
  output logic                      bju_valid,
  output logic [DATA_WIDTH-1:0]     bju_src1,
  output logic [DATA_WIDTH-1:0]     bju_src2,
  output logic [DATA_WIDTH-1:0]     bju_offset,
  output logic [PC_WIDTH-1:0]       bju_pc,
  output logic [7:0]                bju_cx_type,
  input  logic [DATA_WIDTH-1:0]     bju_dest,
  input  logic                      bju_redirect_valid,
  input  logic [PC_WIDTH-1:0]       bju_redirect_target,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [RD_WIDTH-1:0]       wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      redirect_valid,
  output logic [PC_WIDTH-1:0]       redirect_target,
  output logic [$clog2(DEPTH):0]    q_count
`ifdef BJU_PERF_CNT_EN
  ,
  output logic [31:0]               perf_br_cnt,
  output logic [31:0]               perf_redirect_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [DATA_WIDTH-1:0] offset;
    logic [PC_WIDTH-1:0]   pc;
    logic [7:0]            cx_type;
    logic [RD_WIDTH-1:0]   rd;
    logic                  rd_wen;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic              init_done;   // holds enq_ready low through the first post-reset cycle

  logic                  s1_valid, s1_wen, redir_q;
  logic [RD_WIDTH-1:0]   s1_rd;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [PC_WIDTH-1:0]   s1_target;

  logic head_valid, s1_busy, issue, squash, enq_fire;

  // An S1 entry without a register write never waits on wb_ready.
  assign head_valid = (count != '0);
  assign s1_busy    = s1_valid & s1_wen;
  assign issue      = head_valid & (~s1_busy | wb_ready) & ~flush;
  assign squash     = issue & bju_redirect_valid;
  // A dequeue in the same cycle frees a slot, so a full queue can still accept.
  assign enq_ready  = init_done & ((count < CW'(DEPTH)) | issue) & ~flush & ~squash;
  assign enq_fire   = enq_valid & enq_ready;

  assign bju_valid   = issue;
  assign bju_src1    = mem[head].src1;
  assign bju_src2    = mem[head].src2;
  assign bju_offset  = mem[head].offset;
  assign bju_pc      = mem[head].pc;
  assign bju_cx_type = mem[head].cx_type;

  assign wb_valid        = s1_valid & s1_wen;
  assign wb_rd           = s1_rd;
  assign wb_data         = s1_data;
  assign redirect_valid  = redir_q;
  assign redirect_target = s1_target;
  assign q_count         = count;

  // Queue storage and pointers
  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      init_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      init_done <= 1'b1;
      if (enq_fire)
        mem[tail] <= '{src1: enq_src1, src2: enq_src2, offset: enq_offset, pc: enq_pc,
                       cx_type: enq_cx_type, rd: enq_rd, rd_wen: enq_rd_wen};
      if (flush || squash) begin
        // flush clears everything; a taken op discards all younger wrong-path entries
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq_fire) tail <= tail + PW'(1);
        if (issue)    head <= head + PW'(1);
        count <= count + CW'(enq_fire) - CW'(issue);
      end
    end
  end

  // Output stage S1
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_wen    <= 1'b0;
      s1_rd     <= '0;
      s1_data   <= '0;
      s1_target <= '0;
      redir_q   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      redir_q  <= 1'b0;
    end else begin
      // pulse only on the issue edge, even if S1 then stalls on wb_ready
      redir_q <= squash;
      if (issue) begin
        s1_valid  <= 1'b1;
        s1_wen    <= mem[head].rd_wen;
        s1_rd     <= mem[head].rd;
        s1_data   <= bju_dest;
        s1_target <= bju_redirect_target;
      end else if (s1_valid && (wb_ready || !s1_wen)) begin
        s1_valid <= 1'b0;
      end
    end
  end

`ifdef BJU_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_br_cnt       <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (issue)  perf_br_cnt       <= perf_br_cnt + 32'd1;
      if (squash) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
